// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, arbiter state encoding and system clock rate.
package uart_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   localparam int UART_CLK_HZ = 25_000_000;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the serializer handshake around the TX arbiter.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   import uart_pkg::*;

   logic [N_REQ-1:0]  req_valid;
   byte_t [N_REQ-1:0] req_data;
   logic [N_REQ-1:0]  req_last;
   logic [N_REQ-1:0]  req_ready;
   logic              tx_valid;
   byte_t             tx_data;
   logic              tx_ready;

   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_valid, tx_data
   );

   modport master (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_valid, tx_data
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr with wrap.
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [$clog2(N_REQ)-1:0] winner,
   output logic                     any_req
);
   localparam int IDX_W = $clog2(N_REQ);

   always_comb begin
      logic [IDX_W-1:0] idx;
      winner  = '0;
      any_req = 1'b0;
      idx     = ptr;
      for (int i = 0; i < N_REQ; i++) begin
         if (!any_req && req[idx]) begin
            winner  = idx;
            any_req = 1'b1;
         end
         idx = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART byte serializer among N_REQ requesters.
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic                     clk_25mhz,
   input  logic                     rst_n,
   uart_tx_arbiter_if.slave         bus,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic                     timeout_err
);
   import uart_pkg::*;

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(IDLE_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(IDLE_TIMEOUT - 1);

   arb_state_e       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             slot_free;
   logic             xfer;
   logic [CNT_W-1:0] idle_cnt;
   logic [CNT_W-1:0] idle_cnt_inc;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
      return (v == IDX_W'(N_REQ - 1)) ? '0 : v + IDX_W'(1);
   endfunction

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req     (bus.req_valid),
      .ptr     (ptr),
      .winner  (pick_idx),
      .any_req (pick_any)
   );

   assign busy         = (state == ARB_GRANT);
   assign slot_free    = !bus.tx_valid || bus.tx_ready;
   assign xfer         = busy && bus.req_valid[grant_id] && slot_free;
   assign idle_cnt_inc = (idle_cnt == CNT_LIMIT) ? idle_cnt : idle_cnt + CNT_W'(1);

   always_comb begin
      bus.req_ready = '0;
      if (busy) bus.req_ready[grant_id] = slot_free;
   end

   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ARB_IDLE;
         grant_id     <= '0;
         ptr          <= '0;
         idle_cnt     <= '0;
         timeout_err  <= 1'b0;
         bus.tx_valid <= 1'b0;
         bus.tx_data  <= '0;
      end else begin
         timeout_err <= 1'b0;
         // A byte loaded this cycle wins over the drain of the previous one.
         if (bus.tx_ready) bus.tx_valid <= 1'b0;
         if (xfer) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= bus.req_data[grant_id];
         end
         case (state)
            ARB_IDLE: begin
               idle_cnt <= '0;
               if (pick_any) begin
                  grant_id <= pick_idx;
                  state    <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               if (xfer) begin
                  idle_cnt <= '0;
                  if (bus.req_last[grant_id]) begin
                     state <= ARB_IDLE;
                     ptr   <= wrap_inc(grant_id);
                  end
               end else begin
                  idle_cnt <= idle_cnt_inc;
                  // Stalled grant: release without touching a pending tx byte.
                  if (idle_cnt_inc == CNT_LIMIT) begin
                     state       <= ARB_IDLE;
                     ptr         <= wrap_inc(grant_id);
                     timeout_err <= 1'b1;
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N = 4;
   localparam int T = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout_err;

   uart_tx_arbiter_if #(.N_REQ(N)) bus ();

   uart_tx_arbiter #(.N_REQ(N), .IDLE_TIMEOUT(T)) dut (
      .clk_25mhz   (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #20 clk = ~clk;

   int total = 0;
   int passed = 0;

   // Per-requester pending bytes as {last, data}.
   logic [8:0] rq [N][$];
   // Model: byte held for the serializer, grant, pointer, stall count.
   byte_t infl [$];
   logic  m_busy, m_to;
   int    m_g, m_ptr, m_cnt;

   int    txr_mode, pat_i;
   bit    vld_rand;
   byte_t obs_bytes [$];
   int    obs_cyc [$];
   int    dut_grants [$];
   int    gaps [$];
   int    cyc, idle_run, to_pulses, stall_viol, stab_viol, to_busy;
   logic  prev_busy, prev_stall, to_watch, to_arm;
   byte_t prev_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit pending();
      bit p;
      p = m_busy || (infl.size() != 0);
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic clear_logs();
      obs_bytes.delete(); obs_cyc.delete(); dut_grants.delete(); gaps.delete();
      idle_run = 0; to_pulses = 0; stall_viol = 0; stab_viol = 0; to_busy = 0;
   endtask

   task automatic add_byte(input int r, input byte_t d, input logic last);
      rq[r].push_back({last, d});
   endtask

   task automatic cycle();
      logic [N-1:0] vld, exp_rdy;
      logic         txr, found;
      logic [3:0]   pat;
      int           j;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         vld[i] = (rq[i].size() != 0) && (!vld_rand || $urandom_range(0, 3) != 0);
         if (rq[i].size() != 0) begin
            bus.req_data[i] = rq[i][0][7:0];
            bus.req_last[i] = rq[i][0][8];
         end else begin
            bus.req_data[i] = 8'h00;
            bus.req_last[i] = 1'b0;
         end
      end
      pat = 4'b1001;
      case (txr_mode)
         0:       txr = 1'b1;
         1:       txr = ($urandom_range(0, 2) != 0);
         default: begin txr = pat[pat_i % 4]; pat_i++; end
      endcase
      bus.req_valid = vld;
      bus.tx_ready  = txr;
      #1;
      cyc++;
      // Observations taken straight from the DUT outputs.
      if (bus.tx_valid && txr) begin obs_bytes.push_back(bus.tx_data); obs_cyc.push_back(cyc); end
      if (busy && !prev_busy) begin
         dut_grants.push_back(int'(grant_id));
         if (dut_grants.size() > 1) gaps.push_back(idle_run);
         idle_run = 0;
      end else if (!busy) idle_run++;
      prev_busy = busy;
      if (timeout_err) to_pulses++;
      if (bus.tx_valid && !txr && bus.req_ready != '0) stall_viol++;
      if (prev_stall && bus.tx_data !== prev_data) stab_viol++;
      prev_stall = bus.tx_valid && !txr;
      prev_data  = bus.tx_data;
      if (to_arm) begin
         if (timeout_err) to_arm = 1'b0;
         else if (busy) to_busy++;
      end
      if (to_watch && vld[1] && bus.req_ready[1]) begin to_arm = 1'b1; to_watch = 1'b0; end
      // Compare against the model's view of this cycle.
      exp_rdy = '0;
      if (m_busy && (infl.size() == 0 || txr)) exp_rdy[m_g] = 1'b1;
      chk("busy", busy, m_busy);
      chk("grant_id", grant_id, m_g);
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("tx_valid", bus.tx_valid, infl.size() != 0);
      if (infl.size() != 0) chk("tx_data", bus.tx_data, infl[0]);
      chk("timeout_err", timeout_err, m_to);
      // Advance the model across the coming edge.
      m_to = 1'b0;
      if (infl.size() != 0 && txr) void'(infl.pop_front());
      if (m_busy) begin
         if (vld[m_g] && exp_rdy[m_g]) begin
            infl.push_back(bus.req_data[m_g]);
            m_cnt = 0;
            if (bus.req_last[m_g]) begin m_busy = 1'b0; m_ptr = (m_g + 1) % N; end
         end else begin
            m_cnt++;
            if (m_cnt >= T - 1) begin m_busy = 1'b0; m_ptr = (m_g + 1) % N; m_to = 1'b1; end
         end
      end else begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (!found && vld[j]) begin found = 1'b1; m_busy = 1'b1; m_g = j; m_cnt = 0; end
         end
      end
      for (int i = 0; i < N; i++) if (vld[i] && bus.req_ready[i]) void'(rq[i].pop_front());
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (pending() && n < 3000) begin cycle(); n++; end
      chk(tag, n < 3000, 1'b1);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) rq[i].delete();
      infl.delete();
      m_busy = 1'b0; m_to = 1'b0; m_g = 0; m_ptr = 0; m_cnt = 0;
      prev_busy = 1'b0; prev_stall = 1'b0; to_watch = 1'b0; to_arm = 1'b0;
      bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.tx_ready = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic load_contention();
      for (int i = 0; i < N; i++) begin
         add_byte(i, byte_t'(8'h10 + 2 * i), 1'b0);
         add_byte(i, byte_t'(8'h11 + 2 * i), 1'b1);
      end
   endtask

   task automatic check_order(input string tag);
      chk({tag, "_count"}, dut_grants.size(), N);
      for (int i = 0; i < dut_grants.size(); i++) chk(tag, dut_grants[i], i);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_t bp [4];
      int    start;
      txr_mode = 0; vld_rand = 1'b0; pat_i = 0; cyc = 0;
      model_reset();
      clear_logs();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_tx_valid", bus.tx_valid, 1'b0);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_req_ready", bus.req_ready, 4'b0000);
      chk("rst_grant_id", grant_id, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_timeout_err", timeout_err, 1'b0);
      do_reset();

      // Single requester, three bytes.
      clear_logs();
      add_byte(2, 8'h48, 1'b0); add_byte(2, 8'h49, 1'b0); add_byte(2, 8'h0A, 1'b1);
      start = cyc + 1;
      drain("single_drain");
      chk("single_count", obs_bytes.size(), 3);
      if (obs_bytes.size() == 3) begin
         chk("single_b0", obs_bytes[0], 8'h48);
         chk("single_b1", obs_bytes[1], 8'h49);
         chk("single_b2", obs_bytes[2], 8'h0A);
         for (int i = 0; i < 3; i++) chk("single_cycle", obs_cyc[i] - start, 2 + i);
      end
      chk("single_ptr", dut.ptr, 2'd3);

      // Contention from reset.
      do_reset();
      clear_logs();
      load_contention();
      drain("cont_drain");
      check_order("cont_grant");
      for (int i = 0; i < gaps.size(); i++) chk("cont_gap", gaps[i], 1);
      chk("cont_bytes", obs_bytes.size(), 2 * N);

      // Backpressure on a 4-byte packet.
      clear_logs();
      txr_mode = 2; pat_i = 0;
      for (int i = 0; i < 4; i++) begin
         bp[i] = byte_t'($urandom);
         add_byte(0, bp[i], i == 3);
      end
      drain("bp_drain");
      chk("bp_count", obs_bytes.size(), 4);
      for (int i = 0; i < obs_bytes.size() && i < 4; i++) chk("bp_byte", obs_bytes[i], bp[i]);
      chk("bp_ready_in_stall", stall_viol, 0);
      chk("bp_data_stable", stab_viol, 0);

      // Timeout: requester 1 stalls mid-packet, requester 2 waits.
      clear_logs();
      txr_mode = 0;
      add_byte(1, 8'h55, 1'b0);
      add_byte(2, 8'h21, 1'b0); add_byte(2, 8'h22, 1'b1);
      to_watch = 1'b1;
      drain("to_drain");
      chk("to_pulses", to_pulses, 1);
      chk("to_granted_cycles", to_busy, T - 1);
      chk("to_grants", dut_grants.size(), 2);
      if (dut_grants.size() == 2) begin
         chk("to_first", dut_grants[0], 1);
         chk("to_next", dut_grants[1], 2);
      end

      // Random traffic.
      clear_logs();
      txr_mode = 1; vld_rand = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 9) == 0) begin
            int r, len;
            r = $urandom_range(0, N - 1);
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) add_byte(r, byte_t'($urandom), b == len - 1);
         end
         cycle();
      end
      drain("rand_drain");
      vld_rand = 1'b0; txr_mode = 0;

      // Reset applied mid-packet between clock edges.
      clear_logs();
      load_contention();
      for (int c = 0; c < 10 && !bus.tx_valid; c++) cycle();
      chk("rstmid_tx_valid_before", bus.tx_valid, 1'b1);
      #5 rst_n = 1'b0;
      #1;
      chk("rstmid_tx_valid", bus.tx_valid, 1'b0);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_req_ready", bus.req_ready, 4'b0000);
      do_reset();
      clear_logs();
      load_contention();
      drain("rstmid_drain");
      check_order("rstmid_grant");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locked arbiter that shares one UART byte transmitter between N_REQ on-chip requesters (debug printers, status reporters). Each requester presents a valid/ready byte stream with a last-byte marker. The arbiter grants one requester at a time and holds the grant until that requester's packet ends, so messages never interleave on ftdi_txd. It sits between the requester logic and the byte serializer that drives ftdi_txd at 25 MHz, and releases a stalled grant after a timeout.

## Interface
- N_REQ, 4: number of requesters, >= 2, not necessarily a power of two.
- IDLE_TIMEOUT, 1024: granted cycles without a transfer before a forced release, >= 2.
- clk_25mhz  in  1  system clock; the single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  N_REQ x 8  per-requester byte.
- req_last  in  N_REQ  byte is the final byte of the requester's packet.
- req_ready  out  N_REQ  per-requester byte accepted; at most one bit set.
- tx_valid  out  1  byte available to the serializer.
- tx_data  out  8  byte to the serializer.
- tx_ready  in  1  serializer accepts tx_data this cycle.
- grant_id  out  $clog2(N_REQ)  index of the current or most recent grantee.
- busy  out  1  a grant is held (state ARB_GRANT).
- timeout_err  out  1  one-cycle pulse on a forced release.

## Operation
- States: ARB_IDLE, ARB_GRANT.
- ARB_IDLE
  - All req_ready are 0.
  - If any req_valid is set, pick the first set bit scanning ptr, ptr+1, … with wrap modulo N_REQ.
  - Register the winner into grant_id and go to ARB_GRANT.
- ARB_GRANT
  - req_ready[grant_id] = !tx_valid || tx_ready. All other req_ready bits are 0.
- Transfer: req_valid[g] && req_ready[g].
  - Load tx_data <= req_data[g] and set tx_valid <= 1.
  - Clear the timeout counter.
- Output register
  - tx_valid clears on tx_ready unless a new byte loads in the same cycle.
  - While tx_valid is 1, tx_data is stable until tx_ready.
- Release on last: a transfer with req_last[g] moves the arbiter to ARB_IDLE and sets ptr <= (g+1) mod N_REQ.
- Timeout
  - The counter increments on each ARB_GRANT cycle without a transfer.
  - When it reaches IDLE_TIMEOUT-1, the arbiter goes to ARB_IDLE, sets ptr <= (g+1) mod N_REQ, and pulses timeout_err for one cycle.
  - A pending tx byte is kept, not dropped.
- A release never drops a pending tx_valid; the serializer drains it normally.
- Counter width is $clog2(IDLE_TIMEOUT). It saturates and never wraps.

## Timing
- Reset values: tx_valid 0, tx_data 8'h00, req_ready all 0, grant_id 0, busy 0, timeout_err 0, ptr 0, timeout counter 0.
- Reset applied mid-packet clears all state immediately. The in-flight byte is lost; the serializer must tolerate tx_valid falling.
- Arbitration latency:
  - req_valid seen in ARB_IDLE at cycle 0.
  - busy=1 and req_ready high in cycle 1.
  - First byte accepted at the end of cycle 1; tx_valid=1 in cycle 2.
- Throughput: one byte per cycle when tx_ready is held high.
- Dead cycle: exactly one ARB_IDLE cycle between consecutive packets, including back-to-back packets from the same requester.
- Single-byte packets (req_valid and req_last both set on the first byte) are legal.
- The granted requester deasserting req_valid mid-packet keeps the grant; only req_last or the timeout releases it.
- Simultaneous requests are resolved purely by ptr order. A lower index has no fixed priority.

## Structure
- Shared package uart_pkg:
  - typedef byte_t (logic [7:0]).
  - enum arb_state_e {ARB_IDLE, ARB_GRANT}.
  - constant UART_CLK_HZ = 25_000_000.
- Sub-module rr_pick:
  - Combinational; inputs: request vector, ptr.
  - Outputs: winner index and any-request flag.
  - Parameterized by N_REQ; reused by future TX/RX arbiters.
- Top-level state, the output register and the timeout counter live in uart_tx_arbiter.

## Test plan
- Single requester:
  - Stimulus: requester 2 sends 3 bytes 8'h48, 8'h49, 8'h0A with last on the third; tx_ready held 1.
  - Required: tx_data sequence 48, 49, 0A on cycles 2–4; busy falls after the 0A transfer; ptr=3.
- Contention:
  - Stimulus: all 4 requesters valid with 2-byte packets, starting from reset.
  - Required: grants in order 0, 1, 2, 3; no interleaving; exactly one idle cycle between packets.
- Backpressure:
  - Stimulus: tx_ready toggles 1,0,0,1 during a 4-byte packet.
  - Required: req_ready low whenever tx_valid && !tx_ready; tx_data stable while stalled; all 4 bytes delivered in order.
- Timeout (IDLE_TIMEOUT=16):
  - Stimulus: requester 1 sends one non-last byte, then drops req_valid.
  - Required: timeout_err pulses once, 15 granted cycles after that byte's transfer; busy=0; requester 2 is granted next.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 asynchronously between clock edges while tx_valid=1.
  - Required: tx_valid, busy and req_ready drop immediately without a clock; after release, grant order restarts at requester 0.
